// File: rtl/banco_registradores_param_pkg.sv
// Shared types and default widths for the parametrised register file.
package banco_regs_pkg;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

endpackage

// File: rtl/banco_registradores_param_if.sv
// Bus between decode/writeback and the register file: two read ports,
// one write port, clear request and busy status.
interface banco_registradores_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) ();

  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr;
  logic              busy;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr,
    input  rd_data_a, rd_data_b, busy
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr,
    output rd_data_a, rd_data_b, busy
  );

endinterface

// File: rtl/banco_registradores_param_clr_seq.sv
// Clear sequencer: walks an index over every register, one per cycle,
// and reports busy for exactly DEPTH cycles.
module banco_clr_seq
  import banco_regs_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  clr_state_t        state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;

  // State and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next state: clr only matters in IDLE; CLEAR ends after the last index.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (clr) begin
          state_n = CLEAR;
          idx_n   = '0;
        end
      end
      CLEAR: begin
        if (idx == {ADDR_W{1'b1}}) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx + ADDR_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  assign busy    = (state == CLEAR);
  assign clr_we  = (state == CLEAR);
  assign clr_idx = idx;

endmodule

// File: rtl/banco_registradores_param.sv
// Register file: two registered read ports with write-first bypass, one
// write port, and a sequenced clear that zeroes the array on command.
module banco_registradores_param
  import banco_regs_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ZERO_REG0 = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  banco_registradores_param_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_a_p0, rd_b_p0;
  logic [DATA_W-1:0] rd_a_p1, rd_b_p1;

  banco_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (bus.clr),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // A port write lands only in IDLE, loses to a same-cycle clr, and is
  // dropped for r0 when r0 is hard-wired.
  assign wr_ok = bus.wr_en && !busy && !bus.clr &&
                 !((ZERO_REG0 != 0) && (bus.wr_addr == '0));

  // Storage: clear sequencer has priority over the port write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ---- stage p0: read select (hard zero, clear blanking, bypass, array)
  always_comb begin
    rd_a_p0 = mem[bus.rd_addr_a];
    rd_b_p0 = mem[bus.rd_addr_b];
    if (wr_ok && (bus.rd_addr_a == bus.wr_addr)) rd_a_p0 = bus.wr_data;
    if (wr_ok && (bus.rd_addr_b == bus.wr_addr)) rd_b_p0 = bus.wr_data;
    if (busy) begin
      rd_a_p0 = '0;
      rd_b_p0 = '0;
    end
    if ((ZERO_REG0 != 0) && (bus.rd_addr_a == '0)) rd_a_p0 = '0;
    if ((ZERO_REG0 != 0) && (bus.rd_addr_b == '0)) rd_b_p0 = '0;
  end

  // ---- stage p1: registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_p1 <= '0;
      rd_b_p1 <= '0;
    end else begin
      rd_a_p1 <= rd_a_p0;
      rd_b_p1 <= rd_b_p0;
    end
  end

  assign bus.rd_data_a = rd_a_p1;
  assign bus.rd_data_b = rd_b_p1;
  assign bus.busy      = busy;

endmodule
